hit_event_logger: RTL
=====================

// Module: hit_event_logger
// PURPOSE
//  Downstream consumer of the pattern identifier's 'hit' output.
//  - Turns each hit into exactly one counted event (rising-edge detect).
//  - Keeps a 2-digit BCD event count with a sticky overflow flag.
//  - Timestamps the most recent event.
//  - Stretches the event into a visible LED pulse for the board display.
// PARAMETERS
//  STRETCH_CYCLES  12_500_000  LED on-time per event, in clk cycles (>=1)
//  STRETCH_W       24          width of the stretch down-counter (must hold STRETCH_CYCLES-1)
//  TS_W            16          width of the free-running timestamp and last_ts
// PORTS
//  clk            in   1      system clock; all state changes on posedge
//  rst_n          in   1      asynchronous, active-low reset
//  hit            in   1      level from the pattern identifier; high while in target state
//  clear          in   1      synchronous clear of count/flags/timestamp/LED
//  event_pulse    out  1      one-cycle pulse per counted event (registered)
//  hit_count_bcd  out  8      [7:4] tens, [3:0] units, BCD 00..99
//  overflow       out  1      sticky: set when count wraps 99->00
//  last_ts        out  TS_W   timestamp captured at the most recent event
//  led            out  1      stretched event indicator
// BEHAVIOUR
//  Reset (rst_n=0, async): all of the following are 0 and held at 0 until rst_n=1:
//   hit_d, event_pulse, hit_count_bcd=8'h00, overflow, ts counter, last_ts,
//   led, stretch counter; stretch FSM = IDLE.
//  Edge detect:
//   - ev = hit & ~hit_d; hit_d <= hit every cycle, including cycles with clear=1.
//   - A hit held high N cycles counts once; hit high at reset release counts once.
//  Latency: on the posedge that samples ev=1, all of the following update together;
//   they are visible one cycle after hit rises:
//   event_pulse<=1, count increments, last_ts loads, led<=1.
//  event_pulse: equals registered ev; high for exactly one cycle per event.
//  Count (BCD):
//   - units 9 -> 0 with tens+1; 99 -> 00 with overflow<=1.
//   - overflow stays 1 until clear or reset.
//   - Nibbles never hold A-F.
//  Timestamp:
//   - ts increments by 1 every cycle, wraps 2^TS_W-1 -> 0.
//   - last_ts <= ts (pre-increment value) on an event.
//  Stretch FSM:
//   - IDLE: led=0. On ev: load counter STRETCH_CYCLES-1, go ON.
//   - ON: led=1; counter decrements each cycle; at counter 0 with no ev, go IDLE.
//   - ev in ON (retrigger) reloads STRETCH_CYCLES-1 and stays ON.
//   - Single event: led high for exactly STRETCH_CYCLES cycles.
//  clear (sync, priority over ev in the same cycle):
//   - count=00, overflow=0, ts=0, last_ts=0, led=0, FSM=IDLE, event_pulse=0.
//   - A simultaneous event is dropped; hit_d still updates.
//  Reset mid-stretch or mid-count: immediately returns to the reset values above.
//  No combinational path from any input to any output.
// TESTING (bench uses STRETCH_CYCLES=4, TS_W=8)
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 without waiting for clk.
//  2 hit high 1 cycle at ts=5:
//    -> next cycle event_pulse=1 for 1 cycle, count=8'h01, last_ts=5, led=1 for 4 cycles.
//  3 hit held high 10 cycles -> count +1 only, single event_pulse.
//  4 100 isolated hits from 00:
//    -> count 09->10 and 99->00 correct, overflow=1 after 100th, stays 1; clear -> 00, overflow=0.
//  5 Second hit 2 cycles after first -> led stays 1 continuously, falls 4 cycles after 2nd event.
//  6 clear and hit rising in same cycle -> count stays 00, no event_pulse;
//    hit still high next cycle -> still no event.

Source files
------------

// File: rtl/hit_event_logger.sv
// Counts rising edges of the pattern hit, keeps a BCD tally with overflow,
// timestamps the latest event and stretches it into an LED pulse.
module hit_event_logger #(
    parameter int STRETCH_CYCLES = 12_500_000,
    parameter int STRETCH_W      = 24,
    parameter int TS_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hit,
    input  logic            clear,
    output logic            event_pulse,
    output logic [7:0]      hit_count_bcd,
    output logic            overflow,
    output logic [TS_W-1:0] last_ts,
    output logic            led
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ON   = 1'b1;

    localparam logic [STRETCH_W-1:0] LOAD = STRETCH_W'(STRETCH_CYCLES - 1);
    localparam logic [STRETCH_W-1:0] S_ONE = STRETCH_W'(1);
    localparam logic [TS_W-1:0]      TS_ONE = TS_W'(1);

    logic                 hit_d;
    logic                 ev;
    logic [3:0]           units;
    logic [3:0]           tens;
    logic [TS_W-1:0]      ts;
    logic [0:0]           state;
    logic [STRETCH_W-1:0] stretch_cnt;

    assign ev            = hit & ~hit_d;
    assign hit_count_bcd = {tens, units};
    assign led           = (state == ON);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_d       <= 1'b0;
            event_pulse <= 1'b0;
            units       <= 4'd0;
            tens        <= 4'd0;
            overflow    <= 1'b0;
            ts          <= '0;
            last_ts     <= '0;
        end else begin
            // edge history tracks hit even while clear drops the event
            hit_d <= hit;
            if (clear) begin
                event_pulse <= 1'b0;
                units       <= 4'd0;
                tens        <= 4'd0;
                overflow    <= 1'b0;
                ts          <= '0;
                last_ts     <= '0;
            end else begin
                ts          <= ts + TS_ONE;
                event_pulse <= ev;
                if (ev) begin
                    last_ts <= ts;
                    if (units == 4'd9) begin
                        units <= 4'd0;
                        if (tens == 4'd9) begin
                            tens     <= 4'd0;
                            overflow <= 1'b1;
                        end else begin
                            tens <= tens + 4'd1;
                        end
                    end else begin
                        units <= units + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stretch_cnt <= '0;
        end else if (clear) begin
            state       <= IDLE;
            stretch_cnt <= '0;
        end else if (state == IDLE) begin
            if (ev) begin
                state       <= ON;
                stretch_cnt <= LOAD;
            end
        end else begin
            // retrigger restarts the full on-time
            if (ev) begin
                stretch_cnt <= LOAD;
            end else if (stretch_cnt == '0) begin
                state <= IDLE;
            end else begin
                stretch_cnt <= stretch_cnt - S_ONE;
            end
        end
    end

endmodule
